temporizador_jogo: RTL and testbench
====================================

TEMPORIZADOR_JOGO -- requirements
Module: temporizador_jogo

Interface
REQ-001 The block SHALL provide the port `clock`, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL provide the port `reset`, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-003 The block SHALL provide the port `estado_ledsOn`, input, 1 bit: the game FSM is in its LED-on state.
REQ-004 The block SHALL provide the port `estado_ledsOff`, input, 1 bit: the game FSM is in its LED-off state.
REQ-005 The block SHALL provide the port `estado_espera`, input, 1 bit: the game FSM is waiting for a player move.
REQ-006 The block SHALL provide the port `nivel`, input, 2 bits: the difficulty selection.
REQ-007 The block SHALL provide the port `carrega_nivel`, input, 1 bit: request to latch `nivel`.
REQ-008 The block SHALL provide the port `fimLedsOn`, output, 1 bit: the LED-on interval is complete.
REQ-009 The block SHALL provide the port `fimLedsOff`, output, 1 bit: the LED-off interval is complete.
REQ-010 The block SHALL provide the port `timeout`, output, 1 bit: the move-wait interval has expired.
REQ-011 The block SHALL provide the port `erro_entrada`, output, 1 bit: a sticky flag set when more than one estado_* input is high.
REQ-012 The block SHALL provide the port `db_nivel`, output, 2 bits: the latched difficulty.
REQ-013 The block SHALL provide the port `db_fase`, output, 2 bits: the registered phase, encoded 0 = OCIOSO, 1 = ON, 2 = OFF, 3 = ESPERA.
REQ-014 The block SHALL provide the port `db_contagem`, output, 13 bits: the current cycle count.

Function
REQ-015 The requested phase each cycle SHALL be decoded with priority ON (`estado_ledsOn`) > OFF (`estado_ledsOff`) > ESPERA (`estado_espera`) > OCIOSO (none high).
REQ-016 The interval D for each phase SHALL be taken from the latched level, in cycles:
- level 0: ON 1000, OFF 500, ESPERA 5000.
- level 1: ON 750, OFF 250, ESPERA 4000.
- level 2: ON 500, OFF 250, ESPERA 3000.
- level 3: ON 250, OFF 125, ESPERA 2000.
REQ-017 The block SHALL count consecutive cycles in which the same phase is requested; the first such cycle is cycle 1.
REQ-018 The phase's fim output (`fimLedsOn`, `fimLedsOff` or `timeout`) SHALL be high in cycle D and in every later cycle while that phase remains requested, and low otherwise.
REQ-019 The count SHALL saturate at D and never wrap.
REQ-020 A change of requested phase, including a direct change from ON to OFF, SHALL restart the count so that the new phase's cycle 1 is the first cycle it is requested.
REQ-021 A requested phase of OCIOSO SHALL clear the count to 0 and hold all three fim outputs low.
REQ-022 At most one fim output SHALL be high in any cycle.
REQ-023 `carrega_nivel`=1 while the requested phase is OCIOSO SHALL latch `nivel` at the next edge.
REQ-024 `carrega_nivel` SHALL be ignored when the requested phase is not OCIOSO, so that the level never changes mid-interval.
REQ-025 Two or more estado_* inputs high in the same cycle SHALL set `erro_entrada` at the next edge; the flag SHALL be cleared only by reset.
REQ-026 The `db_contagem` count SHALL be 13 bits wide, sufficient for 5000.
REQ-027 The fim outputs SHALL be combinational from the registered count and the current inputs; the `db_*` outputs SHALL be registered.

Reset
REQ-028 While `reset`=0, the count, latched level, phase register and `erro_entrada` SHALL be 0, and all fim outputs SHALL be 0.
REQ-029 An assertion of `reset` in the middle of an interval SHALL abort the interval with no fim pulse.
REQ-030 After `reset` is released, counting SHALL begin at cycle 1 on the first edge with a phase requested.

Structure
REQ-031 A shared package temporizador_pkg SHALL hold:
- the phase encoding;
- the counter width constant, 13;
- the 4x3 duration table, indexed by level and phase.
REQ-032 The counter SHALL be one sub-module, contador_saturado, with ports clear, enable, limit[12:0], count[12:0] and at_limit.

Verification
REQ-033 The bench SHALL cover this scenario: level 0, `estado_ledsOn` held -> `fimLedsOn` first high in cycle 1000 and stays high; lowering the input -> low in the same cycle.
REQ-034 The bench SHALL cover this scenario: level 3, ON held until its fim, then switched directly to OFF -> `fimLedsOff` first high in OFF cycle 125, with no carry-over of the ON count.
REQ-035 The bench SHALL cover this scenario: level 2, `estado_espera` held for 2999 cycles then dropped -> `timeout` never high; re-assert it -> `timeout` first high in cycle 3000.
REQ-036 The bench SHALL cover this scenario: `carrega_nivel` with `nivel`=1 while ON is requested -> `db_nivel` stays 0; repeat while OCIOSO -> `db_nivel`=1 after one edge.
REQ-037 The bench SHALL cover this scenario: `estado_ledsOn` and `estado_espera` both high -> ON timing used, `erro_entrada`=1 at the next edge and still 1 after the inputs clear.
REQ-038 The bench SHALL cover this scenario: `reset` pulsed low at ON cycle 600 -> all outputs 0 during reset; after release with ON still held, fim is first high 1000 cycles later.

Source files
------------

// File: rtl/temporizador_pkg.sv
// Shared definitions for the game timer: phase encoding, counter width and
// the per-level interval table.
package temporizador_pkg;

  typedef enum logic [1:0] {
    FASE_OCIOSO = 2'd0,
    FASE_ON     = 2'd1,
    FASE_OFF    = 2'd2,
    FASE_ESPERA = 2'd3
  } fase_t;

  localparam int LARGURA_CONTADOR = 13;

  // Rows are difficulty levels 0..3; columns are ON, OFF, ESPERA in cycles.
  localparam logic [LARGURA_CONTADOR-1:0] TABELA_DURACAO [4][3] = '{
    '{13'd1000, 13'd500, 13'd5000},
    '{13'd750,  13'd250, 13'd4000},
    '{13'd500,  13'd250, 13'd3000},
    '{13'd250,  13'd125, 13'd2000}
  };

  function automatic logic [LARGURA_CONTADOR-1:0] duracao(input logic [1:0] nivel,
                                                          input fase_t fase);
    logic [LARGURA_CONTADOR-1:0] d;
    d = '0;
    case (fase)
      FASE_ON:     d = TABELA_DURACAO[nivel][0];
      FASE_OFF:    d = TABELA_DURACAO[nivel][1];
      FASE_ESPERA: d = TABELA_DURACAO[nivel][2];
      default:     d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Cycle counter that saturates at a limit; a clear with enable restarts it
// at 1 so the first cycle of a new phase is counted immediately.
module contador_saturado
  import temporizador_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        enable,
  input  logic [LARGURA_CONTADOR-1:0] limit,
  output logic [LARGURA_CONTADOR-1:0] count,
  output logic                        at_limit
);

  logic [LARGURA_CONTADOR-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= {{(LARGURA_CONTADOR-1){1'b0}}, enable};
    end else if (enable && (r_count < limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count    = r_count;
  assign at_limit = (r_count >= limit);

endmodule

// File: rtl/temporizador_jogo.sv
// Game interval timer: decodes the requested phase, times it against the
// latched difficulty level and flags the end of each interval.
module temporizador_jogo
  import temporizador_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        estado_ledsOn,
  input  logic                        estado_ledsOff,
  input  logic                        estado_espera,
  input  logic [1:0]                  nivel,
  input  logic                        carrega_nivel,
  output logic                        fimLedsOn,
  output logic                        fimLedsOff,
  output logic                        timeout,
  output logic                        erro_entrada,
  output logic [1:0]                  db_nivel,
  output logic [1:0]                  db_fase,
  output logic [LARGURA_CONTADOR-1:0] db_contagem
);

  fase_t                       w_fase;
  fase_t                       r_fase;
  logic [1:0]                  r_nivel;
  logic                        r_erro;
  logic                        w_multiplos;
  logic                        w_mesma;
  logic                        w_reinicia;
  logic                        w_ativo;
  logic                        w_fim;
  logic                        w_no_limite;
  logic [LARGURA_CONTADOR-1:0] w_limite;
  logic [LARGURA_CONTADOR-1:0] w_contagem;

  always_comb begin
    w_fase = FASE_OCIOSO;
    if (estado_ledsOn)       w_fase = FASE_ON;
    else if (estado_ledsOff) w_fase = FASE_OFF;
    else if (estado_espera)  w_fase = FASE_ESPERA;
  end

  assign w_multiplos = (estado_ledsOn & estado_ledsOff) |
                       (estado_ledsOn & estado_espera)  |
                       (estado_ledsOff & estado_espera);

  assign w_limite   = duracao(r_nivel, w_fase);
  assign w_ativo    = (w_fase != FASE_OCIOSO);
  assign w_mesma    = w_ativo && (w_fase == r_fase);
  assign w_reinicia = !w_mesma;

  contador_saturado u_contador (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_reinicia),
    .enable   (w_ativo),
    .limit    (w_limite),
    .count    (w_contagem),
    .at_limit (w_no_limite)
  );

  // The registered count lags by one cycle, so cycle D is reached when it holds D-1.
  assign w_fim = reset && w_mesma &&
                 (w_no_limite || (w_contagem == (w_limite - 1'b1)));

  assign fimLedsOn  = w_fim && (w_fase == FASE_ON);
  assign fimLedsOff = w_fim && (w_fase == FASE_OFF);
  assign timeout    = w_fim && (w_fase == FASE_ESPERA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fase  <= FASE_OCIOSO;
      r_nivel <= 2'd0;
      r_erro  <= 1'b0;
    end else begin
      r_fase <= w_fase;
      if (carrega_nivel && !w_ativo) r_nivel <= nivel;
      if (w_multiplos)               r_erro  <= 1'b1;
    end
  end

  assign erro_entrada = r_erro;
  assign db_nivel     = r_nivel;
  assign db_fase      = r_fase;
  assign db_contagem  = w_contagem;

endmodule

// File: tb/tb_temporizador_jogo.sv
// Randomized and directed bench for temporizador_jogo against a run-length
// reference model of the phase timing rules.
module tb_temporizador_jogo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        estado_ledsOn = 1'b0;
  logic        estado_ledsOff = 1'b0;
  logic        estado_espera = 1'b0;
  logic [1:0]  nivel = 2'd0;
  logic        carrega_nivel = 1'b0;
  logic        fimLedsOn;
  logic        fimLedsOff;
  logic        timeout;
  logic        erro_entrada;
  logic [1:0]  db_nivel;
  logic [1:0]  db_fase;
  logic [12:0] db_contagem;

  int checksTotal = 0;
  int checksPassed = 0;

  // Reference model state: phase requested last cycle, its run length, level, error.
  int duracaoRef [4][4];
  int mPrev = 0;
  int mRun = 0;
  int mNivel = 0;
  bit mErro = 1'b0;

  temporizador_jogo dut (
    .clock          (clock),
    .reset          (reset),
    .estado_ledsOn  (estado_ledsOn),
    .estado_ledsOff (estado_ledsOff),
    .estado_espera  (estado_espera),
    .nivel          (nivel),
    .carrega_nivel  (carrega_nivel),
    .fimLedsOn      (fimLedsOn),
    .fimLedsOff     (fimLedsOff),
    .timeout        (timeout),
    .erro_entrada   (erro_entrada),
    .db_nivel       (db_nivel),
    .db_fase        (db_fase),
    .db_contagem    (db_contagem)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0d expected %0d at %0t",
                  tag, observed, expected, $time);
  endtask

  function automatic int pedido(input bit on, input bit off, input bit esp);
    if (on)  return 1;
    if (off) return 2;
    if (esp) return 3;
    return 0;
  endfunction

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic applyStimulus(input bit on, input bit off, input bit esp,
                               input logic [1:0] niv, input bit carr);
    int req;
    int runNow;
    int dur;
    estado_ledsOn  = on;
    estado_ledsOff = off;
    estado_espera  = esp;
    nivel          = niv;
    carrega_nivel  = carr;
    req = pedido(on, off, esp);
    if (req == 0)          runNow = 0;
    else if (req == mPrev) runNow = mRun + 1;
    else                   runNow = 1;
    dur = duracaoRef[mNivel][req];
    #4;
    checkOutput("fimLedsOn",  16'(fimLedsOn),  16'(req == 1 && runNow >= dur));
    checkOutput("fimLedsOff", 16'(fimLedsOff), 16'(req == 2 && runNow >= dur));
    checkOutput("timeout",    16'(timeout),    16'(req == 3 && runNow >= dur));
    @(posedge clock);
    #1;
    if (carr && req == 0) mNivel = int'(niv);
    if (int'(on) + int'(off) + int'(esp) >= 2) mErro = 1'b1;
    mPrev = req;
    mRun  = runNow;
    checkOutput("db_contagem",  16'(db_contagem),  16'((runNow < dur) ? runNow : dur));
    checkOutput("db_fase",      16'(db_fase),      16'(req));
    checkOutput("db_nivel",     16'(db_nivel),     16'(mNivel));
    checkOutput("erro_entrada", 16'(erro_entrada), 16'(mErro));
  endtask

  task automatic holdPhase(input bit on, input bit off, input bit esp, input int n);
    for (int i = 0; i < n; i++) applyStimulus(on, off, esp, 2'd0, 1'b0);
  endtask

  task automatic loadLevel(input logic [1:0] niv);
    applyStimulus(1'b0, 1'b0, 1'b0, niv, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_fimLedsOn"},   16'(fimLedsOn),    16'd0);
    checkOutput({tag, "_fimLedsOff"},  16'(fimLedsOff),   16'd0);
    checkOutput({tag, "_timeout"},     16'(timeout),      16'd0);
    checkOutput({tag, "_erro"},        16'(erro_entrada), 16'd0);
    checkOutput({tag, "_db_nivel"},    16'(db_nivel),     16'd0);
    checkOutput({tag, "_db_fase"},     16'(db_fase),      16'd0);
    checkOutput({tag, "_db_contagem"}, 16'(db_contagem),  16'd0);
  endtask

  // Asynchronous reset pulse while the current inputs stay applied.
  task automatic pulseReset(input int n);
    reset = 1'b0;
    #2;
    checkAllZero("reset_enter");
    mPrev  = 0;
    mRun   = 0;
    mNivel = 0;
    mErro  = 1'b0;
    repeat (n) @(posedge clock);
    #3;
    checkAllZero("reset_hold");
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int sel;
    int len;
    bit on;
    bit off;
    bit esp;

    duracaoRef = '{'{0, 1000, 500, 5000}, '{0, 750, 250, 4000},
                   '{0, 500, 250, 3000},  '{0, 250, 125, 2000}};

    #2;
    checkAllZero("por");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Level 0, ON held past its interval, then dropped.
    loadLevel(2'd0);
    holdPhase(1'b1, 1'b0, 1'b0, 1005);
    holdPhase(1'b0, 1'b0, 1'b0, 2);

    // Level 3, ON to its end then straight into OFF.
    loadLevel(2'd3);
    holdPhase(1'b1, 1'b0, 1'b0, 250);
    holdPhase(1'b0, 1'b1, 1'b0, 130);
    holdPhase(1'b0, 1'b0, 1'b0, 1);

    // Level 2, ESPERA one cycle short, dropped, then held to timeout.
    loadLevel(2'd2);
    holdPhase(1'b0, 1'b0, 1'b1, 2999);
    holdPhase(1'b0, 1'b0, 1'b0, 1);
    holdPhase(1'b0, 1'b0, 1'b1, 3003);
    holdPhase(1'b0, 1'b0, 1'b0, 1);

    // Level load refused mid-phase, accepted while idle.
    loadLevel(2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    checkOutput("nivel_ignored_in_on", 16'(db_nivel), 16'd0);
    loadLevel(2'd1);
    checkOutput("nivel_loaded_idle", 16'(db_nivel), 16'd1);

    // Conflicting ON and ESPERA: ON timing wins and the error sticks.
    holdPhase(1'b1, 1'b0, 1'b1, 755);
    checkOutput("erro_set", 16'(erro_entrada), 16'd1);
    holdPhase(1'b0, 1'b0, 1'b0, 3);
    checkOutput("erro_sticky", 16'(erro_entrada), 16'd1);

    // Reset in the middle of ON, then ON retimed from scratch.
    loadLevel(2'd0);
    holdPhase(1'b1, 1'b0, 1'b0, 600);
    pulseReset(3);
    mPrev = 1;
    mRun  = 1;
    checkOutput("post_reset_count", 16'(db_contagem), 16'd1);
    holdPhase(1'b1, 1'b0, 1'b0, 1004);
    holdPhase(1'b0, 1'b0, 1'b0, 1);

    // Random segments with level changes and direct phase switches.
    for (int s = 0; s < 14; s++) begin
      loadLevel(2'($urandom_range(0, 3)));
      for (int k = 0; k < 2; k++) begin
        sel = $urandom_range(0, 9);
        on = 1'b0; off = 1'b0; esp = 1'b0;
        if (sel <= 2)      on  = 1'b1;
        else if (sel <= 5) off = 1'b1;
        else if (sel <= 8) esp = 1'b1;
        else begin
          on  = 1'($urandom_range(0, 1));
          off = 1'($urandom_range(0, 1));
          esp = 1'($urandom_range(0, 1));
        end
        len = $urandom_range(1, 1200);
        holdPhase(on, off, esp, len);
      end
    end
    holdPhase(1'b0, 1'b0, 1'b0, 2);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
